aes_lite_param_core: RTL and testbench

Parametrised iterative lightweight block cipher core. It is the next generation of the fixed 8-bit aes_lite FSM.
- Generalises data/key width and round count.
- Adds a decrypt mode, a start/valid/ready handshake and output back-pressure.
- Sits behind the TinyTapeout pin wrapper. The wrapper maps pins to start/mode/data/key and exposes out_valid as the ready flag.

---
 rtl/aes_lite_param_core.sv | 180 ++++++++++++++++++
 tb/tb_aes_lite_param_core.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_lite_param_core.sv
// Iterative lightweight block cipher core (PRESENT S-box + rotate + key-add), DATA_W bits, ROUNDS rounds.
// Latency: encrypt ROUNDS+1 cycles, decrypt 2*ROUNDS+1 cycles from the accepting edge to out_valid.
// Backpressure: result held in DONE with out_valid high until out_ready; start accepted only in IDLE.
//
// Ports:
//   clk, rst_n      clock and synchronous active-low reset
//   start, mode     request (IDLE only) and direction (0 = encrypt, 1 = decrypt)
//   data_in, key_in operands, sampled together with start
//   busy            high whenever the core is not IDLE
//   out_valid       result valid (DONE state)
//   out_ready       consumer accepts the result
//   data_out        result register, kept until the next operation completes
//   round_cnt       current round index (debug)
module aes_lite_param_core #(
    parameter int DATA_W = 8,
    parameter int ROUNDS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              mode,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] key_in,
    output logic              busy,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] data_out,
    output logic [3:0]        round_cnt
);

    typedef enum logic [1:0] {IDLE, KEYX, ROUND, DONE} state_t;

    localparam logic [3:0] LAST = 4'(ROUNDS);

    state_t            state, state_nx;
    logic [DATA_W-1:0] s_q, s_nx;
    logic [DATA_W-1:0] k_q, k_nx;
    logic [DATA_W-1:0] dout_q, dout_nx;
    logic              mode_q, mode_nx;
    logic [3:0]        cnt_q, cnt_nx;

    logic [DATA_W-1:0] k_fwd, k_bwd, enc_s, dec_s;

    function automatic logic [3:0] sbox4(input logic [3:0] x);
        case (x)
            4'h0: sbox4 = 4'hC;  4'h1: sbox4 = 4'h5;  4'h2: sbox4 = 4'h6;  4'h3: sbox4 = 4'hB;
            4'h4: sbox4 = 4'h9;  4'h5: sbox4 = 4'h0;  4'h6: sbox4 = 4'hA;  4'h7: sbox4 = 4'hD;
            4'h8: sbox4 = 4'h3;  4'h9: sbox4 = 4'hE;  4'hA: sbox4 = 4'hF;  4'hB: sbox4 = 4'h8;
            4'hC: sbox4 = 4'h4;  4'hD: sbox4 = 4'h7;  4'hE: sbox4 = 4'h1;  default: sbox4 = 4'h2;
        endcase
    endfunction

    function automatic logic [3:0] sinv4(input logic [3:0] x);
        case (x)
            4'h0: sinv4 = 4'h5;  4'h1: sinv4 = 4'hE;  4'h2: sinv4 = 4'hF;  4'h3: sinv4 = 4'h8;
            4'h4: sinv4 = 4'hC;  4'h5: sinv4 = 4'h1;  4'h6: sinv4 = 4'h2;  4'h7: sinv4 = 4'hD;
            4'h8: sinv4 = 4'hB;  4'h9: sinv4 = 4'h4;  4'hA: sinv4 = 4'h6;  4'hB: sinv4 = 4'h3;
            4'hC: sinv4 = 4'h0;  4'hD: sinv4 = 4'h7;  4'hE: sinv4 = 4'h9;  default: sinv4 = 4'hA;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] sub_word(input logic [DATA_W-1:0] x, input logic inv);
        logic [DATA_W-1:0] y;
        y = '0;
        for (int i = 0; i < DATA_W / 4; i++) begin
            y[4*i +: 4] = inv ? sinv4(x[4*i +: 4]) : sbox4(x[4*i +: 4]);
        end
        return y;
    endfunction

    function automatic logic [DATA_W-1:0] rotl(input logic [DATA_W-1:0] x, input int n);
        return (x << n) | (x >> (DATA_W - n));
    endfunction

    function automatic logic [DATA_W-1:0] rotr(input logic [DATA_W-1:0] x, input int n);
        return (x >> n) | (x << (DATA_W - n));
    endfunction

    function automatic logic [DATA_W-1:0] rc(input logic [3:0] r);
        return {{(DATA_W-4){1'b0}}, r};
    endfunction

    // k_q holds k_{r-1} before encrypt round r and k_r before decrypt round r,
    // so both directions step the key alongside the state in the same cycle.
    always_comb begin
        k_fwd = rotl(k_q, 3) ^ rc(cnt_q);
        k_bwd = rotr(k_q ^ rc(cnt_q), 3);
        enc_s = rotl(sub_word(s_q, 1'b0), 1) ^ k_fwd;
        dec_s = sub_word(rotr(s_q ^ k_q, 1), 1'b1);
    end

    always_comb begin
        state_nx = state;
        s_nx     = s_q;
        k_nx     = k_q;
        dout_nx  = dout_q;
        mode_nx  = mode_q;
        cnt_nx   = cnt_q;
        case (state)
            IDLE: begin
                if (start) begin
                    mode_nx = mode;
                    k_nx    = key_in;
                    cnt_nx  = 4'd1;
                    if (mode) begin
                        s_nx     = data_in;
                        state_nx = KEYX;
                    end else begin
                        s_nx     = data_in ^ key_in;
                        state_nx = ROUND;
                    end
                end
            end
            KEYX: begin
                // Walk the schedule forward to k_ROUNDS; the counter parks at ROUNDS
                // so decrypt rounds can count down from there.
                k_nx = k_fwd;
                if (cnt_q == LAST) begin
                    state_nx = ROUND;
                end else begin
                    cnt_nx = cnt_q + 4'd1;
                end
            end
            ROUND: begin
                if (!mode_q) begin
                    s_nx = enc_s;
                    k_nx = k_fwd;
                    if (cnt_q == LAST) begin
                        dout_nx  = enc_s;
                        state_nx = DONE;
                    end else begin
                        cnt_nx = cnt_q + 4'd1;
                    end
                end else begin
                    k_nx = k_bwd;
                    if (cnt_q == 4'd1) begin
                        // Inverse key step from k_1 yields k0, the final whitening key.
                        s_nx     = dec_s ^ k_bwd;
                        dout_nx  = dec_s ^ k_bwd;
                        state_nx = DONE;
                    end else begin
                        s_nx   = dec_s;
                        cnt_nx = cnt_q - 4'd1;
                    end
                end
            end
            DONE: begin
                // start is deliberately not looked at here: the handshake cycle only returns to IDLE.
                if (out_ready) begin
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            s_q    <= '0;
            k_q    <= '0;
            dout_q <= '0;
            mode_q <= 1'b0;
            cnt_q  <= 4'd0;
        end else begin
            state  <= state_nx;
            s_q    <= s_nx;
            k_q    <= k_nx;
            dout_q <= dout_nx;
            mode_q <= mode_nx;
            cnt_q  <= cnt_nx;
        end
    end

    assign busy      = (state != IDLE);
    assign out_valid = (state == DONE);
    assign data_out  = dout_q;
    assign round_cnt = cnt_q;

endmodule

// File: tb/tb_aes_lite_param_core.sv
module tb_aes_lite_param_core;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // 8-bit / 4-round instance
    logic       rst8_n, start8, mode8, ready8, busy8, valid8;
    logic [7:0] din8, key8, dout8;
    logic [3:0] rc8;

    // 16-bit / 15-round instance
    logic        rst16_n, start16, mode16, ready16, busy16, valid16;
    logic [15:0] din16, key16, dout16;
    logic [3:0]  rc16;

    aes_lite_param_core #(.DATA_W(8), .ROUNDS(4)) u8 (
        .clk(clk), .rst_n(rst8_n), .start(start8), .mode(mode8),
        .data_in(din8), .key_in(key8), .busy(busy8), .out_valid(valid8),
        .out_ready(ready8), .data_out(dout8), .round_cnt(rc8)
    );

    aes_lite_param_core #(.DATA_W(16), .ROUNDS(15)) u16 (
        .clk(clk), .rst_n(rst16_n), .start(start16), .mode(mode16),
        .data_in(din16), .key_in(key16), .busy(busy16), .out_valid(valid16),
        .out_ready(ready16), .data_out(dout16), .round_cnt(rc16)
    );

    // ---------------- reference model ----------------
    localparam logic [3:0] SB [16] = '{4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
                                       4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2};
    logic [3:0] si [16];

    function automatic logic [15:0] mrotl(input logic [15:0] x, input int n, input int w);
        logic [15:0] m;
        m = 16'hFFFF >> (16 - w);
        return ((x << n) | (x >> (w - n))) & m;
    endfunction

    function automatic logic [15:0] msub(input logic [15:0] x, input int w, input bit inv);
        logic [15:0] y;
        y = 16'h0;
        for (int i = 0; i < w / 4; i++) begin
            y[4*i +: 4] = inv ? si[x[4*i +: 4]] : SB[x[4*i +: 4]];
        end
        return y;
    endfunction

    function automatic logic [15:0] ref_cipher(input bit dec, input logic [15:0] d, input logic [15:0] k,
                                               input int w, input int nr);
        logic [15:0] ks [16];
        logic [15:0] s;
        ks[0] = k;
        for (int r = 1; r <= nr; r++) ks[r] = mrotl(ks[r-1], 3, w) ^ 16'(r);
        if (!dec) begin
            s = d ^ ks[0];
            for (int r = 1; r <= nr; r++) s = mrotl(msub(s, w, 1'b0), 1, w) ^ ks[r];
        end else begin
            s = d;
            for (int r = nr; r >= 1; r--) s = msub(mrotl(s ^ ks[r], w - 1, w), w, 1'b1);
            s = s ^ ks[0];
        end
        return s;
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one operation on an idle instance and wait (bounded) for out_valid.
    // lat = 1 for the cycle that begins at the accepting edge.
    task automatic run_op(input bit wide, input bit m, input logic [15:0] d, input logic [15:0] k,
                          output logic [15:0] res, output int lat);
        @(negedge clk);
        if (wide) begin
            start16 = 1'b1; mode16 = m; din16 = d; key16 = k;
        end else begin
            start8 = 1'b1; mode8 = m; din8 = d[7:0]; key8 = k[7:0];
        end
        @(posedge clk);
        #1;
        start8 = 1'b0; start16 = 1'b0;
        // scramble inputs after acceptance; they must not matter
        din8 = 8'($urandom); key8 = 8'($urandom); mode8 = ~m;
        din16 = 16'($urandom); key16 = 16'($urandom); mode16 = ~m;
        lat = 1;
        @(negedge clk);
        while (!(wide ? valid16 : valid8) && lat < 80) begin
            @(negedge clk);
            lat++;
        end
        res = wide ? dout16 : {8'h00, dout8};
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] res, ct, pt, d, k;
        int lat, n;

        for (int i = 0; i < 16; i++) si[SB[i]] = 4'(i);

        rst8_n = 1'b0; rst16_n = 1'b0;
        start8 = 1'b0; mode8 = 1'b0; din8 = 8'h0; key8 = 8'h0; ready8 = 1'b1;
        start16 = 1'b0; mode16 = 1'b0; din16 = 16'h0; key16 = 16'h0; ready16 = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_busy8", {15'h0, busy8}, 16'h0);
        check("rst_valid8", {15'h0, valid8}, 16'h0);
        check("rst_dout8", {8'h0, dout8}, 16'h0);
        check("rst_rc8", {12'h0, rc8}, 16'h0);
        check("rst_busy16", {15'h0, busy16}, 16'h0);
        check("rst_dout16", dout16, 16'h0);
        rst8_n = 1'b1; rst16_n = 1'b1;

        // 1: encrypt 00/00
        run_op(1'b0, 1'b0, 16'h00, 16'h00, res, lat);
        check("t1_valid", {15'h0, valid8}, 16'h1);
        check("t1_lat", 16'(lat), 16'd5);
        check("t1_data", res, 16'h0070);

        // 2: encrypt AA/55 with round counter trace
        @(negedge clk);
        start8 = 1'b1; mode8 = 1'b0; din8 = 8'hAA; key8 = 8'h55;
        @(posedge clk);
        #1 start8 = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            check("t2_round_cnt", {12'h0, rc8}, 16'(i));
            check("t2_busy", {15'h0, busy8}, 16'h1);
        end
        @(negedge clk);
        check("t2_valid", {15'h0, valid8}, 16'h1);
        check("t2_data", {8'h0, dout8}, 16'h00EC);

        // 3: decrypts
        run_op(1'b0, 1'b1, 16'hEC, 16'h55, res, lat);
        check("t3_lat", 16'(lat), 16'd9);
        check("t3_data_aa", res, 16'h00AA);
        run_op(1'b0, 1'b1, 16'h70, 16'h00, res, lat);
        check("t3_lat2", 16'(lat), 16'd9);
        check("t3_data_00", res, 16'h0000);

        // 4: backpressure and ignored start pulses
        @(negedge clk);
        ready8 = 1'b0;
        start8 = 1'b1; mode8 = 1'b0; din8 = 8'hAA; key8 = 8'h55;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (2) @(negedge clk);
        start8 = 1'b1; mode8 = 1'b1; din8 = 8'h12; key8 = 8'h34;
        @(posedge clk);
        #1 start8 = 1'b0;
        n = 0;
        @(negedge clk);
        while (!valid8 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("t4_valid", {15'h0, valid8}, 16'h1);
        check("t4_data", {8'h0, dout8}, 16'h00EC);
        for (int i = 0; i < 10; i++) begin
            start8 = (i == 3);
            @(negedge clk);
            check("t4_hold_valid", {15'h0, valid8}, 16'h1);
            check("t4_hold_data", {8'h0, dout8}, 16'h00EC);
        end
        start8 = 1'b1; mode8 = 1'b0; din8 = 8'h00; key8 = 8'h00; ready8 = 1'b1;
        @(posedge clk);
        #1 start8 = 1'b0;
        @(negedge clk);
        check("t4_idle_busy", {15'h0, busy8}, 16'h0);
        check("t4_idle_valid", {15'h0, valid8}, 16'h0);
        check("t4_idle_data", {8'h0, dout8}, 16'h00EC);
        @(negedge clk);
        check("t4_no_accept", {15'h0, busy8}, 16'h0);

        // 5: reset during round 2
        @(negedge clk);
        start8 = 1'b1; mode8 = 1'b0; din8 = 8'hAA; key8 = 8'h55;
        @(posedge clk);
        #1 start8 = 1'b0;
        repeat (2) @(negedge clk);
        check("t5_round2", {12'h0, rc8}, 16'h2);
        rst8_n = 1'b0;
        @(posedge clk);
        #1 rst8_n = 1'b1;
        @(negedge clk);
        check("t5_busy", {15'h0, busy8}, 16'h0);
        check("t5_valid", {15'h0, valid8}, 16'h0);
        check("t5_dout", {8'h0, dout8}, 16'h0);
        check("t5_rc", {12'h0, rc8}, 16'h0);
        repeat (3) @(negedge clk);
        check("t5_stay_idle", {15'h0, valid8 | busy8}, 16'h0);
        run_op(1'b0, 1'b0, 16'hAA, 16'h55, res, lat);
        check("t5_lat", 16'(lat), 16'd5);
        check("t5_data", res, 16'h00EC);

        // 6: 16-bit / 15-round random round trips
        for (int i = 0; i < 200; i++) begin
            d = 16'($urandom);
            k = 16'($urandom);
            run_op(1'b1, 1'b0, d, k, ct, lat);
            check("t6_enc_lat", 16'(lat), 16'd16);
            check("t6_enc_data", ct, ref_cipher(1'b0, d, k, 16, 15));
            run_op(1'b1, 1'b1, ct, k, pt, lat);
            check("t6_dec_lat", 16'(lat), 16'd31);
            check("t6_roundtrip", pt, d);
        end

        // a few random 8-bit checks against the model as well
        for (int i = 0; i < 20; i++) begin
            d = {8'h0, 8'($urandom)};
            k = {8'h0, 8'($urandom)};
            run_op(1'b0, i[0], d, k, res, lat);
            check("t7_data8", res, ref_cipher(i[0], d, k, 8, 4));
        end

        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
